// File: rtl/mole_board.sv
// Whack-a-mole board: raised-mole state, per-hole lifetime timers, hit/miss/whiff
// detection from debounced button levels, and a saturating hit score.
module mole_board #(
  parameter int unsigned N_HOLES = 5,
  parameter int unsigned LIFE_W  = 8,
  parameter int unsigned SCORE_W = 8,
  localparam int unsigned CNT_W  = $clog2(N_HOLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               load,
  input  logic [N_HOLES-1:0] loadval,
  input  logic [LIFE_W-1:0]  lifetime,
  input  logic [N_HOLES-1:0] button,
  input  logic               clear_score,
  output logic [N_HOLES-1:0] board_state,
  output logic               hit_pulse,
  output logic [CNT_W-1:0]   hit_num,
  output logic               miss_pulse,
  output logic               whiff_pulse,
  output logic [SCORE_W-1:0] score
);

  logic [N_HOLES-1:0] button_q;
  logic [N_HOLES-1:0] board_q, board_d;
  logic [LIFE_W-1:0]  timer_q [N_HOLES];
  logic [LIFE_W-1:0]  timer_d [N_HOLES];
  logic               hit_pulse_q, hit_pulse_d;
  logic [CNT_W-1:0]   hit_num_q, hit_num_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic               whiff_pulse_q, whiff_pulse_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [N_HOLES-1:0] press;
  logic [N_HOLES-1:0] hit_vec;
  logic [N_HOLES-1:0] expire_vec;
  logic [N_HOLES-1:0] whiff_vec;
  logic [SCORE_W:0]   score_sum;

  // Presses are rising edges seen while the game runs; history tracks regardless of enable.
  assign press = button & ~button_q & {N_HOLES{enable}};

  always_comb begin
    board_d    = board_q;
    timer_d    = timer_q;
    hit_vec    = '0;
    expire_vec = '0;
    whiff_vec  = '0;
    hit_num_d  = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      if (board_q[i]) begin
        if (press[i]) begin
          hit_vec[i] = 1'b1;
          board_d[i] = 1'b0;
          timer_d[i] = '0;
        end else if (enable) begin
          if (timer_q[i] == LIFE_W'(1)) begin
            expire_vec[i] = 1'b1;
            board_d[i]    = 1'b0;
            timer_d[i]    = '0;
          end else begin
            timer_d[i] = timer_q[i] - LIFE_W'(1);
          end
        end
      end else if (press[i]) begin
        whiff_vec[i] = 1'b1;
      end
      // A load wins for the next state, but events from the pre-load state still report.
      if (load && loadval[i] && (lifetime != '0)) begin
        board_d[i] = 1'b1;
        timer_d[i] = lifetime;
      end
      hit_num_d = hit_num_d + CNT_W'(hit_vec[i]);
    end
    hit_pulse_d   = (hit_num_d != '0);
    miss_pulse_d  = |expire_vec;
    whiff_pulse_d = |whiff_vec;
  end

  always_comb begin
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hit_num_d);
    if (clear_score) begin
      score_d = '0;
    end else if (score_sum[SCORE_W]) begin
      score_d = '1;
    end else begin
      score_d = score_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      button_q      <= '0;
      board_q       <= '0;
      hit_pulse_q   <= 1'b0;
      hit_num_q     <= '0;
      miss_pulse_q  <= 1'b0;
      whiff_pulse_q <= 1'b0;
      score_q       <= '0;
      for (int i = 0; i < N_HOLES; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      button_q      <= button;
      board_q       <= board_d;
      hit_pulse_q   <= hit_pulse_d;
      hit_num_q     <= hit_num_d;
      miss_pulse_q  <= miss_pulse_d;
      whiff_pulse_q <= whiff_pulse_d;
      score_q       <= score_d;
      for (int i = 0; i < N_HOLES; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign board_state = board_q;
  assign hit_pulse   = hit_pulse_q;
  assign hit_num     = hit_num_q;
  assign miss_pulse  = miss_pulse_q;
  assign whiff_pulse = whiff_pulse_q;
  assign score       = score_q;

endmodule

// File: tb/tb_mole_board.sv
// Bench for mole_board: directed scenarios plus random play, all checked against
// a behavioural model tracking remaining lifetime per hole as plain integers.
module tb_mole_board;

  localparam int N  = 5;
  localparam int LW = 8;
  localparam int SW = 4;
  localparam int CW = $clog2(N + 1);
  localparam int SCORE_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          load = 1'b0;
  logic [N-1:0]  loadval = '0;
  logic [LW-1:0] lifetime = '0;
  logic [N-1:0]  button = '0;
  logic          clear_score = 1'b0;
  logic [N-1:0]  board_state;
  logic          hit_pulse;
  logic [CW-1:0] hit_num;
  logic          miss_pulse;
  logic          whiff_pulse;
  logic [SW-1:0] score;

  mole_board #(.N_HOLES(N), .LIFE_W(LW), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .loadval(loadval),
    .lifetime(lifetime), .button(button), .clear_score(clear_score),
    .board_state(board_state), .hit_pulse(hit_pulse), .hit_num(hit_num),
    .miss_pulse(miss_pulse), .whiff_pulse(whiff_pulse), .score(score)
  );

  always #5 clk = ~clk;

  // Model: rem[i] = edges of life left (0 = hole down), prev = button seen last edge.
  int rem [N];
  bit prev [N];
  int m_score;
  int m_hits;
  bit m_miss, m_whiff;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [14:0] dut_vec();
    return {board_state, hit_pulse, hit_num, miss_pulse, whiff_pulse, score};
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = (rem[i] > 0);
    return {b, m_hits != 0, CW'(m_hits), m_miss, m_whiff, SW'(m_score)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      prev[i] = 0;
    end
    m_score = 0;
    m_hits  = 0;
    m_miss  = 0;
    m_whiff = 0;
  endtask

  task automatic model_step();
    int nr;
    bit pressed;
    m_hits  = 0;
    m_miss  = 0;
    m_whiff = 0;
    for (int i = 0; i < N; i++) begin
      pressed = enable && button[i] && !prev[i];
      nr = rem[i];
      if (rem[i] > 0) begin
        if (pressed) begin
          m_hits++;
          nr = 0;
        end else if (enable) begin
          if (rem[i] == 1) begin
            m_miss = 1;
            nr = 0;
          end else begin
            nr = rem[i] - 1;
          end
        end
      end else if (pressed) begin
        m_whiff = 1;
      end
      if (load && loadval[i] && lifetime != 0) nr = int'(lifetime);
      rem[i]  = nr;
      prev[i] = button[i];
    end
    if (clear_score) m_score = 0;
    else if (m_score + m_hits > SCORE_MAX) m_score = SCORE_MAX;
    else m_score = m_score + m_hits;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit ld, input logic [N-1:0] lv, input int lt,
                       input logic [N-1:0] btn, input bit en, input bit clr);
    load = ld;
    loadval = lv;
    lifetime = LW'(lt);
    button = btn;
    enable = en;
    clear_score = clr;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load = 1'b0;
    button = '0;
    enable = 1'b1;
    clear_score = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_vec() !== 15'h0) begin
      miscompares++;
      $display("FAIL reset: outputs got %h want %h", dut_vec(), 15'h0);
    end
  endtask

  task automatic test_basic_hit();
    do_reset();
    cycle(1, 5'b00101, 10, 5'b00000, 1, 0);
    cycle(0, 5'b00000, 0, 5'b00000, 1, 0);
    cycle(0, 5'b00000, 0, 5'b00100, 1, 0);
    vectors++;
    if (dut_vec() !== exp_vec() || board_state !== 5'b00001 || hit_num !== 1 || score !== 1) begin
      miscompares++;
      $display("FAIL basic_hit: got %h want %h", dut_vec(), exp_vec());
    end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 5'b00000, 0, 5'b00100, 1, 0);
      vectors++;
      if (dut_vec() !== exp_vec() || hit_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_hold k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_expiry();
    do_reset();
    cycle(1, 5'b00010, 3, 5'b00000, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 5'b00000, 0, 5'b00000, 1, 0);
      vectors++;
      if (dut_vec() !== exp_vec() || miss_pulse !== (k == 2)) begin
        miscompares++;
        $display("FAIL expiry k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_multi_hit_saturation();
    do_reset();
    // Build score up to 14 with repeated double hits.
    for (int k = 0; k < 7; k++) begin
      cycle(1, 5'b00011, 9, 5'b00000, 1, 0);
      cycle(0, 5'b00000, 0, 5'b00011, 1, 0);
      cycle(0, 5'b00000, 0, 5'b00000, 1, 0);
    end
    cycle(1, 5'b11000, 9, 5'b00000, 1, 0);
    cycle(0, 5'b00000, 0, 5'b11001, 1, 0);
    vectors++;
    if (dut_vec() !== exp_vec() || hit_num !== 2 || whiff_pulse !== 1'b1
        || score !== SW'(SCORE_MAX)) begin
      miscompares++;
      $display("FAIL multi_hit_sat: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(0, 5'b00000, 0, 5'b00000, 1, 1);
    vectors++;
    if (dut_vec() !== exp_vec() || score !== 0) begin
      miscompares++;
      $display("FAIL clear_score: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_collision();
    do_reset();
    cycle(1, 5'b00001, 5, 5'b00000, 1, 0);
    cycle(1, 5'b00001, 7, 5'b00001, 1, 0);
    vectors++;
    if (dut_vec() !== exp_vec() || hit_pulse !== 1'b1 || board_state[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL collision: got %h want %h", dut_vec(), exp_vec());
    end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 5'b00000, 0, 5'b00000, 1, 0);
      vectors++;
      if (dut_vec() !== exp_vec() || miss_pulse !== (k == 6)) begin
        miscompares++;
        $display("FAIL collision_life k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    cycle(1, 5'b00100, 2, 5'b00000, 1, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 5'b00000, 0, (k % 4 < 2) ? 5'b00100 : 5'b00000, 0, 0);
      vectors++;
      if (dut_vec() !== exp_vec() || board_state !== 5'b00100 || hit_pulse || whiff_pulse) begin
        miscompares++;
        $display("FAIL gated k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    // Button still high when enable rises: must not count as a press.
    cycle(0, 5'b00000, 0, 5'b00100, 0, 0);
    cycle(0, 5'b00000, 0, 5'b00100, 1, 0);
    cycle(0, 5'b00000, 0, 5'b00000, 1, 0);
    vectors++;
    if (dut_vec() !== exp_vec() || miss_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_resume: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] btn;
    do_reset();
    btn = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
      cycle($urandom_range(0, 3) == 0, N'($urandom), $urandom_range(0, 6), btn,
            $urandom_range(0, 9) != 0, $urandom_range(0, 60) == 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 5'b11111, 20, 5'b00000, 1, 0);
    cycle(0, 5'b00000, 0, 5'b00001, 1, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== 15'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), 15'h0);
    end
    button = '0;
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 5'b00000, 0, 5'b00000, 1, 0);
      vectors++;
      if (dut_vec() !== exp_vec() || dut_vec() !== 15'h0) begin
        miscompares++;
        $display("FAIL post_reset k=%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic_hit();
    test_expiry();
    test_multi_hit_saturation();
    test_collision();
    test_enable_gating();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
